// File: rtl/avgn_pkg.sv
// Shared derived-width helpers for the avgn moving-average datapath.
package avgn_pkg;

    function automatic int sum_w(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

    function automatic int depth(input int log2_n);
        return 1 << log2_n;
    endfunction

endpackage

// File: rtl/avgn_ring.sv
// Sample delay line for the averager: ring buffer, write pointer and saturating fill count.
module avgn_ring
    import avgn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              i_we,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_oldest,
    output logic              o_full
);

    localparam int N = depth(LOG2_N);
    localparam logic [LOG2_N:0] FILL_MAX = (LOG2_N + 1)'(N);

    logic [DATA_W-1:0] r_buf [N];
    logic [LOG2_N-1:0] r_wptr;
    logic [LOG2_N:0]   r_fill;

    // NOTE: the sample memory is deliberately not reset; fill == 0 masks stale contents.
    always_ff @(posedge CLOCK) begin
        if (i_we) begin
            r_buf[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET || i_clr) begin
            r_wptr <= '0;
            r_fill <= '0;
        end else if (i_we) begin
            r_wptr <= r_wptr + LOG2_N'(1);
            if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + (LOG2_N + 1)'(1);
            end
        end
    end

    assign o_full   = (r_fill == FILL_MAX);
    // Until the window is full the slot being overwritten still counts as zero.
    assign o_oldest = o_full ? r_buf[r_wptr] : '0;

endmodule

// File: rtl/avgn_stream.sv
// Streaming N-tap moving average: running-sum accumulator over avgn_ring, valid/ready on both sides.
module avgn_stream
    import avgn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3,
    parameter int ROUND  = 0
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_full
);

    localparam int SUM_W = sum_w(DATA_W, LOG2_N);
    localparam int N     = depth(LOG2_N);
    localparam logic [SUM_W:0] ROUND_ADD = (ROUND != 0) ? (SUM_W + 1)'(N / 2) : '0;

    logic [SUM_W-1:0]  r_sum;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic              w_accept;
    logic              w_consume;
    logic [DATA_W-1:0] w_oldest;
    logic [SUM_W-1:0]  w_sum_next;
    logic [SUM_W:0]    w_rounded;
    logic              w_unused_round;

    assign in_ready  = !clr && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;

    avgn_ring #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_ring (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .i_we     (w_accept),
        .i_clr    (clr),
        .i_wdata  (in_data),
        .o_oldest (w_oldest),
        .o_full   (out_full)
    );

    // The window sum never exceeds N * (2^DATA_W - 1), so SUM_W bits cannot wrap.
    assign w_sum_next = r_sum + SUM_W'(in_data) - SUM_W'(w_oldest);
    assign w_rounded  = {1'b0, w_sum_next} + ROUND_ADD;
    assign w_unused_round = ^{w_rounded[SUM_W], w_rounded[LOG2_N-1:0]};

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_sum       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (clr) begin
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_sum       <= w_sum_next;
            r_out_data  <= w_rounded[SUM_W-1:LOG2_N];
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_avgn_stream.sv
// Scoreboarded bench: truncating and rounding instances share stimulus; a window model predicts results.
module tb_avgn_stream;

    localparam int N = 8;

    logic       clk;
    logic       tb_rst_n;
    logic       tb_clr;
    logic       tb_in_valid;
    logic [7:0] tb_in_data;
    logic       tb_out_ready;

    logic       rdy0, val0, full0;
    logic [7:0] data0;
    logic       rdy1, val1, full1;
    logic [7:0] data1;

    avgn_stream #(.DATA_W(8), .LOG2_N(3), .ROUND(0)) dut0 (
        .CLOCK(clk), .RESET(tb_rst_n), .clr(tb_clr),
        .in_valid(tb_in_valid), .in_ready(rdy0), .in_data(tb_in_data),
        .out_valid(val0), .out_ready(tb_out_ready), .out_data(data0), .out_full(full0)
    );

    avgn_stream #(.DATA_W(8), .LOG2_N(3), .ROUND(1)) dut1 (
        .CLOCK(clk), .RESET(tb_rst_n), .clr(tb_clr),
        .in_valid(tb_in_valid), .in_ready(rdy1), .in_data(tb_in_data),
        .out_valid(val1), .out_ready(tb_out_ready), .out_data(data1), .out_full(full1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the last N accepted samples, plus the handshake/output state.
    int         win[$];
    bit         mdl_valid = 1'b0;
    logic [7:0] mdl_data0 = 8'h00;
    logic [7:0] mdl_data1 = 8'h00;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    // One clock: drive at negedge, check pre-edge state at +1, advance the model at +3.
    task automatic cycle(input logic v, input logic [7:0] d, input logic ordy,
                         input logic c, input logic rst);
        bit exp_rdy;
        int sum;
        @(negedge clk);
        tb_in_valid  = v;
        tb_in_data   = d;
        tb_out_ready = ordy;
        tb_clr       = c;
        tb_rst_n     = rst;
        #1;
        exp_rdy = !c && (!mdl_valid || ordy);
        check("in_ready0",  rdy0,  exp_rdy);
        check("in_ready1",  rdy1,  exp_rdy);
        check("out_valid0", val0,  mdl_valid);
        check("out_valid1", val1,  mdl_valid);
        check("out_full0",  full0, win.size() == N);
        check("out_full1",  full1, win.size() == N);
        check("out_data0_hold", data0, mdl_data0);
        check("out_data1_hold", data1, mdl_data1);
        #2;
        if (!rst) begin
            win.delete();
            mdl_valid = 1'b0;
            mdl_data0 = 8'h00;
            mdl_data1 = 8'h00;
            q0.delete();
            q1.delete();
        end else if (c) begin
            win.delete();
            mdl_valid = 1'b0;
            q0.delete();
            q1.delete();
        end else if (v && exp_rdy) begin
            win.push_back(int'(d));
            if (win.size() > N) void'(win.pop_front());
            sum = 0;
            foreach (win[i]) sum += win[i];
            mdl_data0 = 8'(sum / N);
            mdl_data1 = 8'((sum + N / 2) / N);
            q0.push_back(mdl_data0);
            q1.push_back(mdl_data1);
            mdl_valid = 1'b1;
        end else if (mdl_valid && ordy) begin
            mdl_valid = 1'b0;
        end
    endtask

    task automatic peek(input string name, input logic [7:0] e0, input logic [7:0] e1);
        check({name, "_trunc"}, data0, e0);
        check({name, "_round"}, data1, e1);
    endtask

    // Monitor: every consumed result is popped and compared against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (val0 === 1'b1 && tb_out_ready === 1'b1) begin
                if (q0.size() == 0) check("sb0_unexpected", 1, 0);
                else check("sb0_data", data0, q0.pop_front());
            end
            if (val1 === 1'b1 && tb_out_ready === 1'b1) begin
                if (q1.size() == 0) check("sb1_unexpected", 1, 0);
                else check("sb1_data", data1, q1.pop_front());
            end
        end
    end

    initial begin
        logic       v, ordy, c, rst;
        logic [7:0] d;
        tb_rst_n     = 1'b0;
        tb_clr       = 1'b0;
        tb_in_valid  = 1'b0;
        tb_in_data   = 8'h00;
        tb_out_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Fill with 0x10: ramp 02..10, full on the 8th, 9th stays 10.
        repeat (9) cycle(1'b1, 8'h10, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        peek("fill_steady", 8'h10, 8'h10);

        // Max value: sum reaches 2040 without wrapping.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (16) cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        peek("max_value", 8'hFF, 8'hFF);

        // Single small sample: truncation gives 0, rounding gives 1.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h04, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        peek("round_one", 8'h00, 8'h01);

        // Backpressure after three 0x08 samples.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 8'h08, 1'b1, 1'b0, 1'b1);
        repeat (5) cycle(1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
        peek("backpressure_hold", 8'h03, 8'h03);
        cycle(1'b1, 8'h08, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        peek("backpressure_release", 8'h04, 8'h04);

        // clr beats a simultaneous sample.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b1, 8'h20, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 8'h20, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 8'h20, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        peek("after_clr", 8'h04, 8'h04);

        // Reset while a result is pending.
        cycle(1'b1, 8'h40, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h40, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        peek("after_reset", 8'h08, 8'h08);

        // Randomised traffic with occasional clr and reset.
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            d    = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
            ordy = ($urandom_range(0, 2) != 0);
            c    = ($urandom_range(0, 24) == 0);
            rst  = ($urandom_range(0, 96) != 0);
            cycle(v, d, ordy, c, rst);
        end

        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("sb0_drained", q0.size(), 0);
        check("sb1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
